glb_rd_addr_gen: RTL and testbench

GLB_RD_ADDR_GEN -- requirements
Module: glb_rd_addr_gen

---
 rtl/glb_pkg.sv | 23 ++
 rtl/glb_tile_cnt.sv | 55 +++++
 rtl/glb_rd_addr_gen.sv | 144 ++++++++++++++
 tb/tb_glb_rd_addr_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// Shared types and geometry helpers for the global-buffer read address generator.
package glb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } glb_state_e;

  // Row advance between consecutive blocks so that kernel windows overlap correctly.
  function automatic int glb_step(input int bufh, input int ksize);
    return (bufh >= ksize) ? bufh - ksize + 1 : 1;
  endfunction

  function automatic int glb_nblk(input int ih, input int bufh, input int ksize);
    return (ih >= bufh) ? (ih - bufh) / glb_step(bufh, ksize) + 1 : 1;
  endfunction

  function automatic int glb_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glb_tile_cnt.sv
// Column/row counter over one BUFH x IW block; column wraps into row.
module glb_tile_cnt
  import glb_pkg::*;
#(
  parameter int IW   = 32,
  parameter int BUFH = 4,
  localparam int CW  = glb_cw(IW),
  localparam int RW  = glb_cw(BUFH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] r,
  output logic [CW-1:0] c,
  output logic          last
);

  localparam logic [CW-1:0] C_MAX = CW'(IW - 1);
  localparam logic [RW-1:0] R_MAX = RW'(BUFH - 1);

  logic [CW-1:0] c_d, c_q;
  logic [RW-1:0] r_d, r_q;

  always_comb begin
    c_d = c_q;
    r_d = r_q;
    if (clr) begin
      c_d = '0;
      r_d = '0;
    end else if (adv) begin
      if (c_q == C_MAX) begin
        c_d = '0;
        r_d = (r_q == R_MAX) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      r_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
    end
  end

  assign c    = c_q;
  assign r    = r_q;
  assign last = (c_q == C_MAX) && (r_q == R_MAX);

endmodule

// File: rtl/glb_rd_addr_gen.sv
// Streams feature-map word addresses block by block (BUFH rows, overlapping by KSIZE-1)
// into the global buffer read port.
module glb_rd_addr_gen
  import glb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int IH    = 32,
  parameter int BUFH  = 4,
  parameter int KSIZE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_init_addr_en,
  input  logic [AW-1:0] data_init_addr,
  input  logic          data_load,
  input  logic          blk_next,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic          blkend,
  output logic          mapend,
  output logic          busy
);

  localparam int STEP = glb_step(BUFH, KSIZE);
  localparam int NBLK = glb_nblk(IH, BUFH, KSIZE);
  localparam int CW   = glb_cw(IW);
  localparam int RW   = glb_cw(BUFH);
  localparam int BRW  = glb_cw(IH);
  localparam logic [BRW-1:0] BR_STEP = BRW'(STEP);
  localparam logic [BRW-1:0] BR_LAST = BRW'((NBLK - 1) * STEP);

  if (BUFH < KSIZE) begin : g_bad_ksize
    $error("glb_rd_addr_gen: BUFH must be >= KSIZE");
  end
  if (IH < BUFH) begin : g_bad_height
    $error("glb_rd_addr_gen: IH must be >= BUFH");
  end
  if (((IH - BUFH) % STEP) != 0) begin : g_bad_step
    $error("glb_rd_addr_gen: (IH-BUFH) must be a multiple of BUFH-KSIZE+1");
  end

  glb_state_e    state_d, state_q;
  logic [AW-1:0] base_d, base_q;
  logic [BRW-1:0] br_d, br_q;
  logic          rd_valid_d, rd_valid_q;
  logic          blkend_d, blkend_q;
  logic          mapend_d, mapend_q;
  logic          busy_d, busy_q;
  logic          cnt_clr, cnt_adv, cnt_last;
  logic [RW-1:0] r_cnt;
  logic [CW-1:0] c_cnt;
  logic          beat;
  logic [AW-1:0] row_w, addr_w;

  glb_tile_cnt #(
    .IW   (IW),
    .BUFH (BUFH)
  ) u_tile_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .r    (r_cnt),
    .c    (c_cnt),
    .last (cnt_last)
  );

  assign beat = (state_q == ST_LOAD) && rd_ready;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    br_d     = br_q;
    cnt_clr  = 1'b0;
    cnt_adv  = 1'b0;
    blkend_d = 1'b0;
    mapend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_init_addr_en) base_d = data_init_addr;
        if (data_load) begin
          state_d = ST_LOAD;
          br_d    = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          cnt_adv = 1'b1;
          if (cnt_last) begin
            blkend_d = 1'b1;
            if (br_q == BR_LAST) begin
              mapend_d = 1'b1;
              state_d  = ST_IDLE;
              br_d     = '0;
            end else begin
              state_d = ST_HOLD;
              br_d    = br_q + BR_STEP;
            end
          end
        end
      end
      ST_HOLD: begin
        if (blk_next) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    rd_valid_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      br_q       <= '0;
      rd_valid_q <= 1'b0;
      blkend_q   <= 1'b0;
      mapend_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      br_q       <= br_d;
      rd_valid_q <= rd_valid_d;
      blkend_q   <= blkend_d;
      mapend_q   <= mapend_d;
      busy_q     <= busy_d;
    end
  end

  // Address is a pure function of registered counters, so it cannot move during a stall.
  assign row_w  = AW'(br_q) + AW'(r_cnt);
  assign addr_w = base_q + row_w * AW'(IW) + AW'(c_cnt);

  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_valid_q ? addr_w : '0;
  assign blkend   = blkend_q;
  assign mapend   = mapend_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_glb_rd_addr_gen.sv
// Bench for glb_rd_addr_gen: fixed vector table, hand sequences and randomized maps
// checked against an index-based reference of the feature-map walk.
module tb_glb_rd_addr_gen;

  localparam int AW        = 32;
  localparam int IW        = 4;
  localparam int IH        = 8;
  localparam int BUFH      = 4;
  localparam int KSIZE     = 3;
  localparam int STEP      = 2;
  localparam int NBLK      = 3;
  localparam int BLK_BEATS = IW * BUFH;
  localparam int TOTAL     = NBLK * BLK_BEATS;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_init_addr_en;
  logic [AW-1:0] data_init_addr;
  logic          data_load;
  logic          blk_next;
  logic          rd_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          blkend;
  logic          mapend;
  logic          busy;

  always #5 clk = ~clk;

  glb_rd_addr_gen #(
    .AW    (AW),
    .IW    (IW),
    .IH    (IH),
    .BUFH  (BUFH),
    .KSIZE (KSIZE)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .data_init_addr_en (data_init_addr_en),
    .data_init_addr    (data_init_addr),
    .data_load         (data_load),
    .blk_next          (blk_next),
    .rd_ready          (rd_ready),
    .rd_valid          (rd_valid),
    .rd_addr           (rd_addr),
    .blkend            (blkend),
    .mapend            (mapend),
    .busy              (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int beats_obs;

  // Reference: 0 idle, 1 streaming, 2 waiting for consumer; m_idx counts beats done in the map.
  int          m_st   = 0;
  int          m_idx  = 0;
  logic [31:0] m_base = '0;
  bit          m_blkend, m_mapend;

  typedef struct {
    bit          r, en;
    logic [31:0] a;
    bit          ld, bn, rdy;
    bit          e_valid;
    logic [31:0] e_addr;
    bit          e_blkend, e_mapend, e_busy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mkv(bit r, bit en, logic [31:0] a, bit ld, bit bn, bit rdy,
                               bit ev, logic [31:0] ea, bit eb, bit em, bit ebusy);
    vec_t v;
    v.r = r; v.en = en; v.a = a; v.ld = ld; v.bn = bn; v.rdy = rdy;
    v.e_valid = ev; v.e_addr = ea; v.e_blkend = eb; v.e_mapend = em; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_addr(int idx);
    int blk, off, row, col;
    blk = idx / BLK_BEATS;
    off = idx % BLK_BEATS;
    row = blk * STEP + off / IW;
    col = off % IW;
    return m_base + 32'(row * IW + col);
  endfunction

  function automatic void model_advance(bit r, bit en, logic [31:0] a, bit ld, bit bn, bit rdy);
    m_blkend = 1'b0;
    m_mapend = 1'b0;
    if (r) begin
      m_st = 0; m_base = '0; m_idx = 0;
    end else begin
      case (m_st)
        0: begin
          if (en) m_base = a;
          if (ld) begin m_st = 1; m_idx = 0; end
        end
        1: if (rdy) begin
          m_idx++;
          if (m_idx % BLK_BEATS == 0) begin
            m_blkend = 1'b1;
            if (m_idx == TOTAL) begin m_mapend = 1'b1; m_st = 0; end
            else m_st = 2;
          end
        end
        default: if (bn) m_st = 1;
      endcase
    end
  endfunction

  task automatic drive(bit r, bit en, logic [31:0] a, bit ld, bit bn, bit rdy);
    rst = r; data_init_addr_en = en; data_init_addr = a;
    data_load = ld; blk_next = bn; rd_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(bit was_rst);
    bit ev;
    ev = (m_st == 1);
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("blkend", 32'(blkend), 32'(m_blkend));
    chk("mapend", 32'(mapend), 32'(m_mapend));
    chk("busy", 32'(busy), 32'(m_st != 0));
    if (ev) chk("rd_addr", rd_addr, model_addr(m_idx));
    else if (was_rst) chk("rd_addr_rst", rd_addr, 32'h0);
  endtask

  task automatic step(bit r, bit en, logic [31:0] a, bit ld, bit bn, bit rdy);
    logic [31:0] prev_addr;
    bit          stalled;
    prev_addr = rd_addr;
    stalled   = rd_valid && !rdy && !r;
    if (rd_valid && rdy && !r) beats_obs++;
    drive(r, en, a, ld, bn, rdy);
    model_advance(r, en, a, ld, bn, rdy);
    tick();
    check_model(r);
    if (stalled && rd_valid) chk("stall_hold", rd_addr, prev_addr);
  endtask

  task automatic run_map(logic [31:0] base, bit rnd);
    int budget;
    bit rdy, bn, ld, en;
    beats_obs = 0;
    budget    = 0;
    step(1'b0, 1'b1, base, 1'b1, 1'b0, 1'b1);
    while (m_st != 0 && budget < 2000) begin
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (m_st == 2) bn = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      else           bn = rnd && ($urandom_range(0, 7) == 0);
      ld = rnd && ($urandom_range(0, 7) == 0);
      en = rnd && ($urandom_range(0, 7) == 0);
      step(1'b0, en, $urandom, ld, bn, rdy);
      budget++;
    end
    chk("map_within_budget", 32'(budget < 2000), 32'h1);
    chk("beat_count", 32'(beats_obs), 32'(TOTAL));
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    tbl[0]  = mkv(1, 0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 0, 0);
    tbl[1]  = mkv(0, 1, 32'h100, 0, 0, 0,  0, 32'h0,   0, 0, 0);
    tbl[2]  = mkv(0, 0, 32'h0,   1, 0, 0,  1, 32'h100, 0, 0, 1);
    tbl[3]  = mkv(0, 0, 32'h0,   0, 0, 0,  1, 32'h100, 0, 0, 1);
    tbl[4]  = mkv(0, 0, 32'h0,   0, 0, 1,  1, 32'h101, 0, 0, 1);
    tbl[5]  = mkv(0, 1, 32'h500, 1, 0, 1,  1, 32'h102, 0, 0, 1);
    tbl[6]  = mkv(0, 0, 32'h0,   0, 1, 0,  1, 32'h102, 0, 0, 1);
    tbl[7]  = mkv(0, 0, 32'h0,   0, 0, 1,  1, 32'h103, 0, 0, 1);
    tbl[8]  = mkv(0, 0, 32'h0,   0, 0, 1,  1, 32'h104, 0, 0, 1);
    tbl[9]  = mkv(1, 0, 32'h0,   0, 0, 1,  0, 32'h0,   0, 0, 0);
    tbl[10] = mkv(0, 1, 32'h100, 1, 0, 0,  1, 32'h100, 0, 0, 1);
    tbl[11] = mkv(1, 0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].a, tbl[i].ld, tbl[i].bn, tbl[i].rdy);
      model_advance(tbl[i].r, tbl[i].en, tbl[i].a, tbl[i].ld, tbl[i].bn, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_blkend", i), 32'(blkend), 32'(tbl[i].e_blkend));
      chk($sformatf("tbl%0d_mapend", i), 32'(mapend), 32'(tbl[i].e_mapend));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_valid || tbl[i].r)
        chk($sformatf("tbl%0d_addr", i), rd_addr, tbl[i].e_addr);
    end

    // Full-rate map with immediate consumer handshakes.
    run_map(32'h100, 1'b0);
    chk("idle_after_map", 32'(busy), 32'h0);

    // Stalls plus ignored load/blk_next/init-address traffic while busy.
    run_map(32'h100, 1'b1);
    run_map(32'h100, 1'b1);

    // Reset landing on beat 5 of the second block.
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    repeat (BLK_BEATS) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("hold_after_blk0", 32'(busy && !rd_valid && blkend), 32'h1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("blk1_first_addr", rd_addr, 32'h108);
    repeat (5) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("blk1_beat5_addr", rd_addr, 32'h10D);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_outputs", {rd_addr[27:0], rd_valid, blkend, mapend, busy}, 32'h0);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    chk("restart_addr", rd_addr, 32'h100);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Address arithmetic wraps modulo 2^32.
    run_map(32'hFFFF_FFF8, 1'b1);
    run_map($urandom, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
